alu_op_driver: RTL and testbench

//  Upstream driver for the registered ALU (clk, opcode[3:0], a[7:0], b[7:0] -> y, zero, overflow).

---
 rtl/alu_drv_pkg.sv | 42 ++++
 rtl/alu_op_driver_sync_fifo.sv | 69 ++++++
 rtl/alu_op_driver.sv | 252 +++++++++++++++++++++++++
 tb/tb_alu_op_driver.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_drv_pkg.sv
// Shared types for the ALU operation driver: command/result records,
// controller state encoding and the tag sequencing helper.
package alu_drv_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;
  localparam int TAG_W  = 8;

  // One ALU operation as presented on the command port
  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_cmd_t;

  // One captured ALU result with the tag of the command that produced it
  typedef struct packed {
    logic [DATA_W-1:0] y;
    logic              zero;
    logic              overflow;
    logic [TAG_W-1:0]  tag;
  } alu_res_t;

  // Command FIFO entry: the tag is bound at accept time and travels with the command
  typedef struct packed {
    alu_cmd_t         cmd;
    logic [TAG_W-1:0] tag;
  } alu_cmd_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    DRAIN = 2'd3
  } drv_state_e;

  // Sequence numbers wrap naturally at the tag width (255 -> 0)
  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] tag);
    return tag + TAG_W'(1);
  endfunction

endpackage

// File: rtl/alu_op_driver_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count. The head entry is
// visible on data_o whenever the FIFO is not empty. Pushes while full and
// pops while empty are ignored. Storage is cleared by reset so the head
// reads as zero after reset.
module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  T                         data_i,
  input  logic                     pop_i,
  output T                         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // Storage write: entries are written at the tail on an accepted push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_driver.sv
// Upstream driver for a registered ALU. Commands arrive on a valid/ready
// stream, are tagged with a wrapping sequence number, queued, and issued to
// the ALU at most one per cycle. A valid/tag shift register tracks each
// issued command until its ALU result is ready, at which point the result
// is captured into a result FIFO and returned in order on a valid/ready
// stream. Issue is credit-limited so the result FIFO can never overflow.
module alu_op_driver #(
  parameter int DATA_W    = alu_drv_pkg::DATA_W,
  parameter int OP_W      = alu_drv_pkg::OP_W,
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int ALU_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_opcode,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_y,
  output logic              res_zero,
  output logic              res_overflow,
  output logic [7:0]        res_tag,
  output logic              busy
);

  import alu_drv_pkg::*;

  // DATA_W/OP_W must match the package widths used by the record types.
  localparam int CCW   = $clog2(CMD_DEPTH) + 1;
  localparam int RCW   = $clog2(RES_DEPTH) + 1;
  localparam int INF_W = $clog2(ALU_LAT + 2);

  // Controller state
  drv_state_e                  state_q;
  drv_state_e                  state_d;
  logic [TAG_W-1:0]            tag_q;

  // Issue pipeline: stage 0 is loaded at the issue edge, the last stage
  // marks the edge at which alu_y/zero/overflow belong to that command.
  logic [ALU_LAT:0]            pipe_v_q;
  logic [ALU_LAT:0][TAG_W-1:0] pipe_tag_q;

  // ALU drive registers
  logic [OP_W-1:0]             alu_opcode_q;
  logic [DATA_W-1:0]           alu_a_q;
  logic [DATA_W-1:0]           alu_b_q;

  // Command FIFO interface
  alu_cmd_entry_t              cmd_in_s;
  alu_cmd_entry_t              cmd_head_s;
  logic                        cmd_push_s;
  logic                        cmd_full_s;
  logic                        cmd_empty_s;
  logic [CCW-1:0]              cmd_count_s;

  // Result FIFO interface
  alu_res_t                    res_in_s;
  alu_res_t                    res_head_s;
  logic                        res_push_s;
  logic                        res_pop_s;
  logic                        res_full_s;
  logic                        res_empty_s;
  logic [RCW-1:0]              res_count_s;

  // Issue control
  logic [INF_W-1:0]            inflight_s;
  logic                        credit_ok_s;
  logic                        issue_s;

  // A command is only taken when a slot is already free; a pop in the same
  // cycle does not open a slot for the incoming command.
  assign cmd_ready  = !cmd_full_s;
  assign cmd_push_s = cmd_valid && cmd_ready;

  // Pack the incoming command with the sequence number it is accepted under
  always_comb begin
    cmd_in_s.cmd.opcode = cmd_opcode;
    cmd_in_s.cmd.a      = cmd_a;
    cmd_in_s.cmd.b      = cmd_b;
    cmd_in_s.tag        = tag_q;
  end

  sync_fifo #(
    .T     (alu_cmd_entry_t),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_push_s),
    .data_i  (cmd_in_s),
    .pop_i   (issue_s),
    .data_o  (cmd_head_s),
    .full_o  (cmd_full_s),
    .empty_o (cmd_empty_s),
    .count_o (cmd_count_s)
  );

  // Number of issued commands whose results have not been captured yet
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i <= ALU_LAT; i++) begin
      inflight_s = inflight_s + INF_W'(pipe_v_q[i]);
    end
  end

  // Every in-flight command already owns a result slot, so the sum of
  // buffered and in-flight results bounds result FIFO occupancy.
  assign credit_ok_s = ((32'(res_count_s) + 32'(inflight_s)) < 32'(RES_DEPTH)) && !res_full_s;

  // Issue decision: head of the command FIFO goes out unless stalled or out of credit
  always_comb begin
    if ((state_q != STALL) && !cmd_empty_s && credit_ok_s) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Controller next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!cmd_empty_s) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cmd_empty_s) begin
          if (inflight_s != '0) begin
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
          end
        end else if (!credit_ok_s) begin
          state_d = STALL;
        end else begin
          state_d = RUN;
        end
      end
      STALL: begin
        if (credit_ok_s) begin
          state_d = RUN;
        end else begin
          state_d = STALL;
        end
      end
      DRAIN: begin
        if (!cmd_empty_s) begin
          state_d = RUN;
        end else if (inflight_s == '0) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state and accept-side sequence number
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_push_s) begin
        tag_q <= next_tag(tag_q);
      end
    end
  end

  // Issue pipeline shift: tags shift unconditionally, the valid bit qualifies them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v_q   <= '0;
      pipe_tag_q <= '0;
    end else begin
      pipe_v_q   <= {pipe_v_q[ALU_LAT-1:0], issue_s};
      pipe_tag_q <= {pipe_tag_q[ALU_LAT-1:0], cmd_head_s.tag};
    end
  end

  // ALU drive registers load on issue and otherwise hold the last command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
    end else if (issue_s) begin
      alu_opcode_q <= cmd_head_s.cmd.opcode;
      alu_a_q      <= cmd_head_s.cmd.a;
      alu_b_q      <= cmd_head_s.cmd.b;
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;

  // Capture record: ALU outputs paired with the tag leaving the pipeline
  always_comb begin
    res_in_s.y        = alu_y;
    res_in_s.zero     = alu_zero;
    res_in_s.overflow = alu_overflow;
    res_in_s.tag      = pipe_tag_q[ALU_LAT];
  end

  assign res_push_s = pipe_v_q[ALU_LAT];
  assign res_pop_s  = res_valid && res_ready;

  sync_fifo #(
    .T     (alu_res_t),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (res_push_s),
    .data_i  (res_in_s),
    .pop_i   (res_pop_s),
    .data_o  (res_head_s),
    .full_o  (res_full_s),
    .empty_o (res_empty_s),
    .count_o (res_count_s)
  );

  // The result head comes straight from FIFO storage, so it is held
  // stable for as long as the consumer withholds res_ready.
  assign res_valid    = !res_empty_s;
  assign res_y        = res_head_s.y;
  assign res_zero     = res_head_s.zero;
  assign res_overflow = res_head_s.overflow;
  assign res_tag      = res_head_s.tag;

  assign busy = (cmd_count_s != '0) || (inflight_s != '0) || res_valid;

endmodule

// File: tb/tb_alu_op_driver.sv
// Scoreboard bench for alu_op_driver with a registered ALU model (1 stage).
module tb_alu_op_driver;
  import alu_drv_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_opcode;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] alu_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_y = 8'h00;
  logic       alu_zero = 1'b0;
  logic       alu_overflow = 1'b0;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_y;
  logic       res_zero;
  logic       res_overflow;
  logic [7:0] res_tag;
  logic       busy;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_acc = 0;
  int         n_res = 0;
  int         mark_n = 0;
  int         first_res_cyc = 0;
  int         last_res_cyc = 0;
  int         cyc = 0;
  logic [7:0] exp_tag = 8'd0;
  alu_res_t   sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  alu_op_driver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_opcode   (cmd_opcode),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_y        (alu_y),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_y        (res_y),
    .res_zero     (res_zero),
    .res_overflow (res_overflow),
    .res_tag      (res_tag),
    .busy         (busy)
  );

  // ALU behaviour: {y, zero, overflow}
  function automatic logic [9:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] y;
    logic       o;
    s = 9'd0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; y = s[7:0]; o = s[8]; end
      4'd1: begin y = a - b; o = (a < b); end
      4'd2: begin y = a & b; o = 1'b0; end
      default: begin y = 8'h00; o = 1'b0; end
    endcase
    return {y, (y == 8'h00), o};
  endfunction

  // Registered ALU, one stage
  always @(posedge clk) {alu_y, alu_zero, alu_overflow} <= alu_model(alu_opcode, alu_a, alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every handshaken result against the scoreboard head
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
      alu_res_t got;
      alu_res_t e;
      got.y = res_y; got.zero = res_zero; got.overflow = res_overflow; got.tag = res_tag;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %0h expected none", got);
      end else begin
        e = sb.pop_front();
        check("result", 32'(got), 32'(e));
      end
      if (n_res == mark_n) first_res_cyc = cyc;
      last_res_cyc = cyc;
      n_res++;
    end
  end

  // The result FIFO must never be pushed while full
  initial forever begin
    @(posedge clk);
    if (rst_n === 1'b1 && dut.res_push_s === 1'b1 && dut.res_full_s === 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL res_fifo_overflow: got push-while-full expected none");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Offer one command; on acceptance push the expected result
  task automatic send_raw(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ey, input logic ez, input logic eo);
    int       n;
    logic     acc;
    alu_res_t e;
    n = 0;
    acc = 1'b0;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
    while (!acc && n < 400) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (acc) begin
      e.y = ey; e.zero = ez; e.overflow = eo; e.tag = exp_tag;
      sb.push_back(e);
      exp_tag = exp_tag + 8'd1;
      n_acc++;
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL cmd_accept_timeout: got no accept expected accept");
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [9:0] m;
    m = alu_model(op, a, b);
    send_raw(op, a, b, m[9:2], m[1], m[0]);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (4) begin @(posedge clk); #1; end
    check({name, "_drained"}, 32'(sb.size()), 32'd0);
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    exp_tag = 8'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_alu"}, 32'({alu_opcode, alu_a, alu_b}), 32'd0);
    check({name, "_res"}, 32'({res_valid, res_y, res_zero, res_overflow, res_tag}), 32'd0);
    check({name, "_ctl"}, 32'({cmd_ready, busy}), 32'b10);
  endtask

  initial begin
    int n;
    int base;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = 4'd0; cmd_a = 8'd0; cmd_b = 8'd0; res_ready = 1'b0;
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single command and minimum latency
    res_ready = 1'b1;
    send_raw(4'd0, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("t1_valid_e%0d", k), 32'(res_valid), 32'(k == 3));
    end
    wait_drain("t1");

    // 2: carry out to zero, then subtract to zero
    do_reset();
    res_ready = 1'b1;
    send_raw(4'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    send_raw(4'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0);
    wait_drain("t2");

    // 3: back-pressure with 10 commands
    do_reset();
    res_ready = 1'b0;
    n_acc = 0;
    base = n_res;
    fork
      begin
        for (int i = 0; i < 10; i++) send(4'(i % 3), 8'(i * 17 + 1), 8'(i * 5 + 2));
      end
    join_none
    repeat (20) begin @(posedge clk); #1; end
    check("t3_buffered", 32'(dut.res_count_s), 32'd4);
    check("t3_state", 32'(dut.state_q), 32'(STALL));
    check("t3_cmd_ready", 32'(cmd_ready), 32'd0);
    check("t3_accepted", 32'(n_acc), 32'd8);
    res_ready = 1'b1;
    n = 0;
    while (n_acc < 10 && n < 100) begin @(posedge clk); #1; n++; end
    wait_drain("t3");
    check("t3_results", 32'(n_res - base), 32'd10);

    // 4: full-rate stream of 300 with tag wrap
    do_reset();
    res_ready = 1'b1;
    mark_n = n_res;
    for (int i = 0; i < 300; i++) send(4'(i % 3), 8'(i), 8'(i * 7));
    wait_drain("t4");
    check("t4_results", 32'(n_res - mark_n), 32'd300);
    check("t4_rate", 32'(last_res_cyc - first_res_cyc), 32'd299);

    // 5: reset with 2 in flight and 3 queued
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(4'd0, 8'(i), 8'h10);
    repeat (4) begin @(posedge clk); #1; end
    fork
      send(4'd2, 8'hAA, 8'h0F);
    join_none
    res_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    n = 0;
    while (!(dut.inflight_s == 2 && dut.cmd_count_s == 3) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("t5_setup", 32'(n < 20), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_reset");
    sb.delete();
    exp_tag = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("t5_no_stale", 32'(res_valid), 32'd0);
    send_raw(4'd0, 8'h21, 8'h12, 8'h33, 1'b0, 1'b0);
    wait_drain("t5");

    // 6: capture and pop in the same cycle at 3 entries
    do_reset();
    res_ready = 1'b0;
    send_raw(4'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
    send_raw(4'd0, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0);
    send_raw(4'd1, 8'h09, 8'h03, 8'h06, 1'b0, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    check("t6_pre_count", 32'(dut.res_count_s), 32'd3);
    send_raw(4'd0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("t6_count", 32'(dut.res_count_s), 32'd3);
    check("t6_head", 32'({res_y, res_tag}), 32'h3301);
    res_ready = 1'b1;
    wait_drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
